// File: rtl/alu_exec_stage.sv
// alu_exec_stage: multicycle ALU execute stage.
// Latches a, b and op on an accepted start, evaluates the selected operation from
// those registers during EXEC and captures result and flags at the EXEC->DONE edge.
// Fixed 2-cycle latency, one operation per 2 cycles when start is held high.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   start    request; accepted only in IDLE or DONE
//   op       operation select (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR)
//   a, b     operands
//   busy     high while in EXEC
//   done     one-cycle pulse after result/flags are updated
//   result   registered result, held until the next write
//   zero     registered result == 0
//   carryout registered adder carry-out (ADD/SUB only)
//   overflow registered signed overflow (ADD/SUB only)
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpXor  = 3'b010;
    localparam logic [2:0] OpSlt  = 3'b011;
    localparam logic [2:0] OpAnd  = 3'b100;
    localparam logic [2:0] OpNand = 3'b101;
    localparam logic [2:0] OpNor  = 3'b110;
    localparam logic [2:0] OpOr   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             accept;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, carry_q, ovf_q;

    logic [WIDTH:0]   sum, diff;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] res_d;
    logic             carry_d, ovf_d;

    // Datapath: driven only from the latched operand registers.
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
        sub_ovf = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (op_q)
            OpAdd: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = add_ovf;
            end
            OpSub: begin
                res_d   = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];
                ovf_d   = sub_ovf;
            end
            OpXor:  res_d = a_q ^ b_q;
            // Signed less-than: the difference sign is wrong exactly when it overflowed.
            OpSlt:  res_d = {{(WIDTH-1){1'b0}}, diff[Msb] ^ sub_ovf};
            OpAnd:  res_d = a_q & b_q;
            OpNand: res_d = ~(a_q & b_q);
            OpNor:  res_d = ~(a_q | b_q);
            OpOr:   res_d = a_q | b_q;
            default: res_d = '0;
        endcase
    end

    // Next-state logic; start is ignored (not queued) while in EXEC.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: state_d = StDone;
            StDone: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
            if (state_q == StExec) begin
                result_q <= res_d;
                zero_q   <= ~|res_d;
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign busy     = (state_q == StExec);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign zero     = zero_q;
    assign carryout = carry_q;
    assign overflow = ovf_q;

endmodule
